// File: rtl/key_control.sv
// rtl/key_control.sv - synchronised, debounced key conditioner with run/stop control
// Each channel: 2-flop sync, stable-count debounce, press/release pulses; run flips or clears on presses.
module key_control #(
  parameter int                N_KEYS          = 4,
  parameter int                ACTIVE_LOW      = 1,
  parameter int                DEBOUNCE_CYCLES = 50000,
  parameter int                DEBOUNCE_W      = 16,
  parameter logic [N_KEYS-1:0] TOGGLE_MASK     = 4'b0011,
  parameter logic [N_KEYS-1:0] CLEAR_MASK      = 4'b0100
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [N_KEYS-1:0] key_async,
  output logic [N_KEYS-1:0] key_level,
  output logic [N_KEYS-1:0] key_press,
  output logic [N_KEYS-1:0] key_release,
  output logic              run,
  output logic              run_changed
);

  // Channel state is not stored separately: it is {level, count running}.
  typedef enum logic [1:0] {
    ST_RELEASED     = 2'b00,
    ST_PRESS_PEND   = 2'b01,
    ST_PRESSED      = 2'b10,
    ST_RELEASE_PEND = 2'b11
  } chan_state_t;

  localparam logic [DEBOUNCE_W-1:0] TERM = DEBOUNCE_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [DEBOUNCE_W-1:0] ONE  = DEBOUNCE_W'(1);

  logic [N_KEYS-1:0]     w_sample;
  logic [N_KEYS-1:0]     r_sync1;
  logic [N_KEYS-1:0]     r_sync2;
  logic [N_KEYS-1:0]     r_level;
  logic [N_KEYS-1:0]     r_press;
  logic [N_KEYS-1:0]     r_release;
  logic [DEBOUNCE_W-1:0] r_cnt [N_KEYS];
  logic                  r_run;
  logic                  r_run_changed;

  logic [N_KEYS-1:0]     w_level_next;
  logic [N_KEYS-1:0]     w_press_next;
  logic [N_KEYS-1:0]     w_release_next;
  logic [DEBOUNCE_W-1:0] w_cnt_next [N_KEYS];
  chan_state_t           w_state [N_KEYS];
  logic                  w_clr;
  logic                  w_tog;
  logic                  w_run_next;

  assign w_sample = (ACTIVE_LOW != 0) ? ~key_async : key_async;

  always_comb begin
    w_level_next   = r_level;
    w_press_next   = '0;
    w_release_next = '0;
    for (int i = 0; i < N_KEYS; i++) begin
      w_cnt_next[i] = r_cnt[i];
      w_state[i]    = chan_state_t'({r_level[i], r_cnt[i] != '0});
      case (w_state[i])
        ST_RELEASED, ST_PRESS_PEND: begin
          if (!r_sync2[i]) begin
            w_cnt_next[i] = '0;
          end else if (r_cnt[i] == TERM) begin
            w_level_next[i] = 1'b1;
            w_cnt_next[i]   = '0;
            w_press_next[i] = 1'b1;
          end else begin
            w_cnt_next[i] = r_cnt[i] + ONE;
          end
        end
        default: begin
          if (r_sync2[i]) begin
            w_cnt_next[i] = '0;
          end else if (r_cnt[i] == TERM) begin
            w_level_next[i]   = 1'b0;
            w_cnt_next[i]     = '0;
            w_release_next[i] = 1'b1;
          end else begin
            w_cnt_next[i] = r_cnt[i] + ONE;
          end
        end
      endcase
    end
  end

  // A key present in both masks only clears; any number of toggles flips once.
  always_comb begin
    w_clr      = |(w_press_next & CLEAR_MASK);
    w_tog      = |(w_press_next & TOGGLE_MASK & ~CLEAR_MASK);
    w_run_next = r_run;
    if (w_clr) begin
      w_run_next = 1'b0;
    end else if (w_tog) begin
      w_run_next = ~r_run;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_sync1       <= '0;
      r_sync2       <= '0;
      r_level       <= '0;
      r_press       <= '0;
      r_release     <= '0;
      r_run         <= 1'b0;
      r_run_changed <= 1'b0;
      for (int i = 0; i < N_KEYS; i++) begin
        r_cnt[i] <= '0;
      end
    end else begin
      r_sync1       <= w_sample;
      r_sync2       <= r_sync1;
      r_level       <= w_level_next;
      r_press       <= w_press_next;
      r_release     <= w_release_next;
      r_run         <= w_run_next;
      r_run_changed <= (w_run_next != r_run);
      for (int i = 0; i < N_KEYS; i++) begin
        r_cnt[i] <= w_cnt_next[i];
      end
    end
  end

  assign key_level   = r_level;
  assign key_press   = r_press;
  assign key_release = r_release;
  assign run         = r_run;
  assign run_changed = r_run_changed;

endmodule

// File: tb/tb_key_control.sv
// tb/tb_key_control.sv - directed bench for key_control
// Inputs change 1ns after a rising edge; outputs are sampled at the same point.
module tb_key_control;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] key_async;
  logic [3:0] key_level;
  logic [3:0] key_press;
  logic [3:0] key_release;
  logic       run;
  logic       run_changed;

  // Pin change before edge 0 -> pulse on edge 1+DEBOUNCE_CYCLES, i.e. the 6th sampled edge.
  localparam int LAT = 6;

  int n_tests = 0;
  int n_fail  = 0;
  int edge_no = 0;
  int press_cnt [4];
  int rel_cnt [4];
  int press_edge [4];
  int rc_cnt;
  int viol = 0;
  int base;
  logic [3:0] prev_press = '0;
  logic [3:0] prev_rel   = '0;
  logic       prev_rc    = 1'b0;

  key_control #(
    .N_KEYS(4), .ACTIVE_LOW(1), .DEBOUNCE_CYCLES(4), .DEBOUNCE_W(16),
    .TOGGLE_MASK(4'b0011), .CLEAR_MASK(4'b0100)
  ) dut (
    .clk(clk), .rst(rst), .key_async(key_async),
    .key_level(key_level), .key_press(key_press), .key_release(key_release),
    .run(run), .run_changed(run_changed)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic clear_counts();
    for (int c = 0; c < 4; c++) begin
      press_cnt[c]  = 0;
      rel_cnt[c]    = 0;
      press_edge[c] = -1;
    end
    rc_cnt = 0;
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
      edge_no++;
      for (int c = 0; c < 4; c++) begin
        if (key_press[c]) begin
          press_cnt[c]++;
          press_edge[c] = edge_no;
        end
        if (key_release[c]) rel_cnt[c]++;
        if (key_press[c] && key_release[c]) viol++;
        if (key_press[c] && prev_press[c]) viol++;
        if (key_release[c] && prev_rel[c]) viol++;
      end
      if (run_changed) rc_cnt++;
      if (run_changed && prev_rc) viol++;
      prev_press = key_press;
      prev_rel   = key_release;
      prev_rc    = run_changed;
    end
  endtask

  initial begin
    clear_counts();
    rst       = 1'b1;
    key_async = 4'hF;
    step(3);
    check("rst_level", key_level, 0);
    check("rst_press", key_press, 0);
    check("rst_release", key_release, 0);
    check("rst_run", run, 0);
    check("rst_run_changed", run_changed, 0);
    rst = 1'b0;
    clear_counts();
    step(20);
    check("idle_press", press_cnt[0] + press_cnt[1] + press_cnt[2] + press_cnt[3], 0);
    check("idle_release", rel_cnt[0] + rel_cnt[1] + rel_cnt[2] + rel_cnt[3], 0);
    check("idle_rc", rc_cnt, 0);

    // clean press / release of key 0
    clear_counts();
    base = edge_no;
    key_async[0] = 1'b0;
    step(LAT - 1);
    check("k0_early", press_cnt[0], 0);
    step(1);
    check("k0_level", key_level[0], 1);
    check("k0_press", key_press[0], 1);
    check("k0_run", run, 1);
    check("k0_run_changed", run_changed, 1);
    check("k0_press_edge", press_edge[0], base + LAT);
    step(1);
    check("k0_press_width", key_press[0], 0);
    check("k0_rc_width", run_changed, 0);
    step(10);
    clear_counts();
    key_async[0] = 1'b1;
    step(LAT);
    check("k0_release", key_release[0], 1);
    check("k0_level_off", key_level[0], 0);
    check("k0_rel_run", run, 1);
    check("k0_rel_rc", rc_cnt, 0);
    step(10);

    // bouncing key 1: only the final stable low is accepted
    clear_counts();
    key_async[1] = 1'b0; step(3);
    key_async[1] = 1'b1; step(1);
    key_async[1] = 1'b0; step(3);
    key_async[1] = 1'b1; step(1);
    check("k1_bounce_none", press_cnt[1], 0);
    base = edge_no;
    key_async[1] = 1'b0;
    step(12);
    check("k1_press_cnt", press_cnt[1], 1);
    check("k1_press_edge", press_edge[1], base + LAT);
    check("k1_run", run, 0);
    check("k1_rc", rc_cnt, 1);
    key_async[1] = 1'b1;
    step(12);

    // two toggle keys on one edge flip run once
    clear_counts();
    key_async[1:0] = 2'b00;
    step(12);
    check("tt_press0", press_cnt[0], 1);
    check("tt_press1", press_cnt[1], 1);
    check("tt_rc", rc_cnt, 1);
    check("tt_run", run, 1);
    clear_counts();
    key_async[1:0] = 2'b11;
    step(12);
    check("tt_rel_run", run, 1);
    check("tt_rel_rc", rc_cnt, 0);

    // toggle + clear on one edge: clear wins
    clear_counts();
    key_async[0] = 1'b0;
    key_async[2] = 1'b0;
    step(12);
    check("tc_run", run, 0);
    check("tc_rc", rc_cnt, 1);
    key_async = 4'hF;
    step(12);

    // clear while stopped, then an unmasked key
    clear_counts();
    key_async[2] = 1'b0;
    step(12);
    check("clr_press", press_cnt[2], 1);
    check("clr_run", run, 0);
    check("clr_rc", rc_cnt, 0);
    key_async[2] = 1'b1;
    step(12);
    clear_counts();
    key_async[3] = 1'b0;
    step(12);
    check("k3_press", press_cnt[3], 1);
    check("k3_run", run, 0);
    check("k3_rc", rc_cnt, 0);
    key_async[3] = 1'b1;
    step(12);

    // reset with key 0 mid-debounce, key held through reset
    clear_counts();
    key_async[0] = 1'b0;
    step(4);
    rst = 1'b1;
    step(2);
    rst = 1'b0;
    base = edge_no;
    step(LAT - 1);
    check("rm_no_pulse", press_cnt[0], 0);
    check("rm_level", key_level[0], 0);
    step(1);
    check("rm_press", key_press[0], 1);
    check("rm_press_edge", press_edge[0], base + LAT);
    check("rm_run", run, 1);
    key_async[0] = 1'b1;
    step(12);

    check("pulse_rules", viol, 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
